// File: rtl/serial_word_assembler_pkg.sv
// rtl/serial_word_assembler_pkg.sv - shared types and sizing helpers for the serial word assembler
package serial_word_assembler_pkg;

    typedef enum logic {IDLE, SHIFT} asm_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_assembler.sv
// rtl/serial_word_assembler.sv - collects a framed serial bit stream into a WIDTH-bit word
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      sin,
    input  logic                      sin_valid,
    output logic                      busy,
    output logic [cnt_w(WIDTH)-1:0]   bit_count,
    output logic [WIDTH-1:0]          par_out,
    output logic                      ld
);

    localparam int CW = cnt_w(WIDTH);

    asm_state_t       state, state_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt, shifted;
    logic             done;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_count;
        shift_nxt = shift_q;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shift_nxt = '0;
                end
            end
            SHIFT: begin
                // abort wins even over the bit that would complete the word
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shift_nxt = '0;
                end else if (sin_valid) begin
                    if (bit_count == CW'(WIDTH - 1)) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        shift_nxt = '0;
                    end else begin
                        cnt_nxt   = bit_count + CW'(1);
                        shift_nxt = shifted;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                shift_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_count <= '0;
            shift_q   <= '0;
            par_out   <= '0;
            ld        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_count <= cnt_nxt;
            shift_q   <= shift_nxt;
            ld        <= done;
            busy      <= (state_nxt == SHIFT);
            // the completed word includes the bit accepted on this edge
            if (done) begin
                par_out <= shifted;
            end
        end
    end

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Upstream feeder stage for the team's load register: collects a framed serial bit stream into a WIDTH-bit word.
- Presents the completed word on par_out with a one-cycle ld pulse; par_out/ld wire directly to the register's d/ld inputs.
- Handles framing through a start strobe and abort, per-bit qualification through sin_valid, and MSB- or LSB-first ordering.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in par_out[WIDTH-1]; 0 = first bit lands in par_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  begins a frame when sampled high in IDLE.
- abort  input  1  discards the in-progress frame.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is accepted on this edge (SHIFT only).
- busy  output  1  high while in SHIFT.
- bit_count  output  $clog2(WIDTH+1)  bits accepted in the current frame.
- par_out  output  WIDTH  last completed word; drives the load register d.
- ld  output  1  one-cycle registered pulse marking a new par_out word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift reg=0, bit_count=0, par_out=0, ld=0, busy=0. Reset mid-frame drops the partial word; par_out also goes to 0.
- All outputs are registered. busy = (state==SHIFT).
- IDLE:
  - start=1 -> SHIFT, bit_count=0.
  - sin_valid is ignored. abort is ignored.
- SHIFT:
  - Each edge with sin_valid=1 accepts sin and increments bit_count.
    - MSB_FIRST=1: shift left, sin enters bit 0.
    - MSB_FIRST=0: shift right, sin enters bit WIDTH-1.
  - Edges with sin_valid=0 hold all state; gaps of any length are legal.
  - start is ignored while in SHIFT; no restart.
- Completion: on the edge accepting bit WIDTH:
  - par_out <= assembled word, including the bit just accepted.
  - ld <= 1 for exactly the next cycle.
  - state -> IDLE, bit_count -> 0.
  - Latency: ld is high in the cycle after the final-bit edge. The load register captures on the edge that ends that cycle.
- ld=0 on every other cycle. par_out holds its value until the next completion and never shows partial words.
- abort=1 in SHIFT:
  - state -> IDLE, bit_count -> 0, shift reg -> 0.
  - par_out unchanged, no ld.
  - abort takes priority over sin_valid on the same edge, including the would-be final bit.
- Back-to-back frames: start may be asserted in the cycle where ld=1 (state is already IDLE). Minimum frame period is WIDTH+1 cycles.
- start and abort are both level-sampled; holding start high in IDLE re-arms a frame each time IDLE is entered.
- bit_count never exceeds WIDTH-1 as a visible value; it wraps to 0 at completion.

Decomposition:
- Package serial_word_assembler_pkg:
  - typedef enum logic {IDLE, SHIFT} asm_state_t;
  - function cnt_w(width) returning $clog2(width+1).
- No sub-module: a single always_ff for state/counter/shift, plus a next-state always_comb.
- The parent instantiates this block and the load register side by side.

Test Plan:
- Reset then start, WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 with sin_valid every cycle -> par_out=8'hA5 and ld=1 for one cycle, the cycle after the 8th bit; busy falls the same edge.
- MSB_FIRST=0, same bit sequence -> par_out=8'hA5 reversed = 8'hA5; then sequence 1,1,1,1,0,0,0,0 -> par_out=8'h0F.
- Valid gaps: same A5 frame with sin_valid low for 3 cycles after bits 2 and 5 -> par_out=8'hA5, ld single pulse; bit_count holds during gaps.
- Abort after 5 bits following a prior 8'h3C word -> busy=0, bit_count=0, par_out stays 8'h3C, no ld.
- Abort and final bit on the same edge -> no ld, par_out unchanged.
- rst pulled low asynchronously mid-frame (between edges) -> all outputs 0 immediately.
- Back-to-back: start asserted during the ld cycle, second frame 8'hFF -> two ld pulses exactly 9 cycles apart. sin_valid/start pulses in IDLE without start -> no state change.
